// File: rtl/fifo_ctrl_pkg.sv
// Shared types and pointer-flag helpers for the parametrised FIFO controller.
// Pointer helpers take pointers zero-extended to PTR_MAX_W plus the real address width.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, BOTH} fifo_op_t;

  localparam int PTR_MAX_W = 11;

  function automatic logic [PTR_MAX_W-1:0] low_mask(input int aw);
    return PTR_MAX_W'((32'd1 << aw) - 32'd1);
  endfunction

  // Same slot, opposite lap: low bits equal, wrap bit differs.
  function automatic logic flag_full(input logic [PTR_MAX_W-1:0] wp,
                                     input logic [PTR_MAX_W-1:0] rp,
                                     input int aw);
    logic [PTR_MAX_W-1:0] d;
    d = wp ^ rp;
    return ((d & low_mask(aw)) == '0) &&
           ((d & (low_mask(aw + 1) ^ low_mask(aw))) != '0);
  endfunction

  function automatic logic flag_empty(input logic [PTR_MAX_W-1:0] wp,
                                      input logic [PTR_MAX_W-1:0] rp,
                                      input int aw);
    return ((wp ^ rp) & low_mask(aw + 1)) == '0;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: ADDR_W address bits plus one lap bit, increments on inc.
module fifo_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W:0]   ptr
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) ptr <= '0;
    else if (inc) ptr <= ptr + PTR_ONE;
  end

endmodule

// File: rtl/fifo_ctrl_param.sv
// Single-clock FIFO pointer/flag controller driving an external dual-port RAM.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_ctrl_param
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = (1 << ADDR_W) - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              err_clr,
  output logic              wen,
  output logic              ren,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wp, rp;
  logic            wr_acc, rd_acc;
  fifo_op_t        state, state_nxt;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wp (.clock(clock), .rst(rst), .inc(wr_acc), .ptr(wp));
  fifo_ptr #(.ADDR_W(ADDR_W)) u_rp (.clock(clock), .rst(rst), .inc(rd_acc), .ptr(rp));

  // Flags come from registered pointers only, so a same-cycle read never rescues a write.
  assign full         = flag_full(PTR_MAX_W'(wp), PTR_MAX_W'(rp), ADDR_W);
  assign empty        = flag_empty(PTR_MAX_W'(wp), PTR_MAX_W'(rp), ADDR_W);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  assign wr_acc = wr_req & ~full;
  assign rd_acc = rd_req & ~empty;

  always_comb begin
    state_nxt = IDLE;
    case ({wr_acc, rd_acc})
      2'b10:   state_nxt = WRITE;
      2'b01:   state_nxt = READ;
      2'b11:   state_nxt = BOTH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      w_addr <= '0;
      r_addr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (wr_acc) w_addr <= wp[ADDR_W-1:0];
      if (rd_acc) r_addr <= rp[ADDR_W-1:0];
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign wen = (state == WRITE) || (state == BOTH);
  assign ren = (state == READ)  || (state == BOTH);

`ifdef FIFO_ERR_FLAGS_EN
  // A set condition on the same edge as err_clr takes priority.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_req & full)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rd_req & empty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
Parametrised FIFO pointer/flag controller for single-clock FIFOs built around a separate dual-port RAM. Accepts independent write and read requests, with simultaneous read and write allowed in one cycle. Generates registered RAM strobes and addresses, full/empty/almost flags and an occupancy count. Sits between the producer/consumer datapath and the storage array, and generalises the existing depth-8, one-operation-per-cycle controller.

Parameters:
ADDR_W, 3, RAM address width; FIFO depth DEPTH = 2**ADDR_W (legal range 2..10).
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).

Ports:
clock  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_req  in  1  producer write request, sampled at the clock edge
rd_req  in  1  consumer read request, sampled at the clock edge
wen  out  1  registered RAM write strobe
ren  out  1  registered RAM read strobe
w_addr  out  ADDR_W  RAM write address, valid while wen=1
r_addr  out  ADDR_W  RAM read address, valid while ren=1
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky error flag (optional feature; tied 0 when the feature is not compiled in)
underflow  out  1  sticky error flag (optional feature; tied 0 when the feature is not compiled in)
err_clr  in  1  clears overflow/underflow (ignored when the feature is not compiled in)

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, also mid-operation): wp=0, rp=0, count=0, wen=0, ren=0, w_addr=0, r_addr=0, state=IDLE, overflow=0, underflow=0. Resulting flags: empty=1, full=0; almost_empty=1 when AE_LEVEL>=0, which is always true; almost_full=0.
- Internal pointers wp and rp are ADDR_W+1 bits. The MSB is the wrap bit. Both increment modulo 2**(ADDR_W+1).
- full = (wp[ADDR_W-1:0]==rp[ADDR_W-1:0]) && (wp[ADDR_W]!=rp[ADDR_W]).
- empty = (wp==rp).
- full and empty are combinational from the registered pointers only; they never depend on the current request inputs.
- Acceptance (combinational): wr_acc = wr_req & ~full; rd_acc = rd_req & ~empty.
- Write while full is dropped. Write while full is NOT rescued by a same-cycle read.
- Read while empty is dropped.
- On a clock edge with wr_acc=1: wen<=1, w_addr<=wp[ADDR_W-1:0] (pre-increment value), and wp<=wp+1.
- On a clock edge with rd_acc=1: ren<=1, r_addr<=rp[ADDR_W-1:0], and rp<=rp+1.
- When a strobe's request is not accepted, that strobe deasserts on the next edge. Its address output holds its last value.
- Latency: request at edge N produces the strobe and address during cycle N+1. Flags and count reflect the operation from cycle N+1 onward.
- count update per edge: +1 if wr_acc only; -1 if rd_acc only; unchanged if both or neither. count never wraps.
- State register (shared enum), updated every edge from the accepted operations:
  - IDLE: no operation accepted.
  - WRITE: wr_acc only.
  - READ: rd_acc only.
  - BOTH: wr_acc and rd_acc.
  - wen = (state==WRITE || state==BOTH); ren = (state==READ || state==BOTH). Any state may transition to any other state on each edge.
- Simultaneous read and write when 0 < count < DEPTH: both accepted, count unchanged, flags unchanged.
- Simultaneous read and write when empty: only the write is accepted.
- Simultaneous read and write when full: only the read is accepted.
- Address wrap: DEPTH-1 -> 0 on the low bits, with the wrap bit toggling.

Optional Feature:
FIFO_ERR_FLAGS_EN:
- When defined:
  - overflow sets on any edge with wr_req & full.
  - underflow sets on any edge with rd_req & empty.
  - Both flags are sticky.
  - err_clr=1 clears both flags on the next edge.
  - If err_clr and a set condition occur in the same edge, the set wins.
- When not defined: no flag registers are built, overflow and underflow are driven 0, and err_clr is unused.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, WRITE, READ, BOTH} fifo_op_t;
  - function flag_full(wp, rp) and function flag_empty(wp, rp), generic over ADDR_W via a parameterised class or explicit width argument.
- One natural sub-module: fifo_ptr.
  - One ADDR_W+1 pointer with an increment enable and async-low reset.
  - Instantiated twice, once for wp and once for rp.

Test Plan:
- Reset then idle (ADDR_W=3): empty=1, full=0, count=0, wen=ren=0, almost_empty=1.
- 8 consecutive writes with rd_req=0: wen high for cycles 1..8 with w_addr 0..7; after the 8th, full=1 and count=8; almost_full=1 from count=7. A 9th write is dropped and w_addr stays 7; with FIFO_ERR_FLAGS_EN, overflow=1.
- From full, 8 reads: r_addr 0..7, then empty=1. A 9th read gives ren=0; with FIFO_ERR_FLAGS_EN, underflow=1; err_clr then clears it.
- Load 3 entries, then 20 cycles of simultaneous rd_req and wr_req: count stays 3, wen=ren=1 every cycle, both addresses wrap 7->0, and the full and empty flags never assert.
- Simultaneous rd_req and wr_req while empty: write only, count 0->1. While full: read only, count 8->7.
- Assert rst mid-burst at count=5: all outputs return to their reset values immediately, without waiting for a clock edge. After release, the first write uses w_addr=0.
